rom_play_ctrl: RTL

ROM_PLAY_CTRL -- requirements
Module: rom_play_ctrl

---
 rtl/rom_play_ctrl_if.sv | 32 +++
 rtl/rom_play_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rom_play_ctrl_if.sv
`timescale 1ns/1ps
// rom_play_ctrl_if -- ROM read bus between the playback controller and a
// synchronous ROM.
//   rom_addr : word address, meaningful while rom_rd is high
//   rom_rd   : read strobe, one cycle per word
//   rom_data : ROM word, valid exactly one cycle after rom_rd
//   state    : controller FSM state (debug visibility only)
// Handshake: a read is requested by rom_rd=1 with rom_addr for one cycle;
// the ROM returns rom_data on the following cycle with no back-pressure.
interface rom_play_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [DATA_W-1:0] rom_data;
    logic [1:0]        state;

    modport master (
        output rom_addr,
        output rom_rd,
        input  rom_data,
        output state
    );

    modport slave (
        input  rom_addr,
        input  rom_rd,
        output rom_data,
        input  state
    );
endinterface

// File: rtl/rom_play_ctrl.sv
`timescale 1ns/1ps
// rom_play_ctrl -- plays a sequence of ROM words at a programmable rate.
//   Clk, Reset   : clock and asynchronous active-high reset
//   start        : one-cycle request to begin playback (IDLE only)
//   stop         : abort playback, no done pulse
//   loop_en      : at end of sequence, wrap to address 0 (sampled live)
//   length       : words to play, latched when start is accepted
//   rate_div     : extra hold cycles per word, latched with start
//   rom          : ROM read bus (address, strobe, returned data)
//   sample_out   : last word fetched; sample_valid pulses when it updates
//   busy         : high whenever not IDLE
//   done         : one-cycle pulse on normal completion or zero-length start
//   loop_count   : completed wraps since the last accepted start (saturating)
// Each word takes FETCH(1) + WAIT(1) + HOLD(DIV+1) = DIV+3 cycles.
module rom_play_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] length,
    input  logic [DIV_W-1:0]  rate_div,
    rom_play_ctrl_if.master   rom,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic [15:0]       loop_count
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt_q;

    // Decoded actions for the datapath, produced alongside the next state.
    logic accept;       // start taken with a non-empty sequence
    logic empty_start;  // start taken with length 0: done only
    logic step;         // move to the next address
    logic wrap;         // end of sequence with looping
    logic finish;       // end of sequence without looping

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        empty_start = 1'b0;
        step        = 1'b0;
        wrap        = 1'b0;
        finish      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // stop has priority over a simultaneous start
                if (start && !stop) begin
                    if (length != '0) begin
                        accept  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        empty_start = 1'b1;
                    end
                end
            end
            S_FETCH: state_d = stop ? S_IDLE : S_WAIT;
            S_WAIT:  state_d = stop ? S_IDLE : S_HOLD;
            S_HOLD: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    if (addr_q != len_q - ADDR_W'(1)) begin
                        step    = 1'b1;
                        state_d = S_FETCH;
                    end else if (loop_en) begin
                        wrap    = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        finish  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            div_q        <= '0;
            cnt_q        <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            loop_count   <= '0;
        end else begin
            state_q      <= state_d;
            sample_valid <= 1'b0;
            done         <= empty_start | finish;

            if (accept) begin
                len_q      <= length;
                div_q      <= rate_div;
                addr_q     <= '0;
                loop_count <= '0;
            end

            // ROM data is valid during WAIT; an abort here leaves sample_out alone
            if (state_q == S_WAIT && !stop) begin
                sample_out   <= rom.rom_data;
                sample_valid <= 1'b1;
                cnt_q        <= div_q;
            end

            if (state_q == S_HOLD && !stop && cnt_q != '0) begin
                cnt_q <= cnt_q - DIV_W'(1);
            end

            if (step) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            if (wrap) begin
                addr_q <= '0;
                if (loop_count != 16'hFFFF) begin
                    loop_count <= loop_count + 16'd1;
                end
            end
        end
    end

    assign rom.rom_addr = addr_q;
    assign rom.rom_rd   = (state_q == S_FETCH);
    assign rom.state    = state_q;
    assign busy         = (state_q != S_IDLE);

endmodule
